// File: rtl/sdp_ram_arb_pkg.sv
// sdp_ram_arb_pkg
//   Shared definitions for the SDP RAM two-requester arbiter:
//   requester ids, the read-return tag carried through the latency
//   pipeline, and the read-latency legality helper.
package sdp_ram_arb_pkg;

   localparam logic ID_M0 = 1'b0;
   localparam logic ID_M1 = 1'b1;

   typedef struct packed {
      logic vld;
      logic id;
   } rd_tag_t;

   // The attached SDP RAM only supports NORMAL (2) or LOW_LATENCY (1).
   function automatic logic legal_rd_lat(input int unsigned lat);
      return (lat == 1) || (lat == 2);
   endfunction

endpackage

// File: rtl/sdp_ram_arb_tagpipe.sv
// sdp_ram_arb_tagpipe
//   DEPTH-deep shift register of read tags with synchronous clear.
//   Ports:
//     clk      clock
//     rst      synchronous active-high clear of every stage
//     in_tag   tag entering stage 0
//     out_tag  tag at stage DEPTH-1
module sdp_ram_arb_tagpipe
   import sdp_ram_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic    clk,
   input  logic    rst,
   input  rd_tag_t in_tag,
   output rd_tag_t out_tag
);

   rd_tag_t stage [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= in_tag;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign out_tag = stage[DEPTH-1];

endmodule

// File: rtl/sdp_ram_arb.sv
// sdp_ram_arb
//   Lets two requesters share one SDP RAM. At most one access (read or
//   write) is granted per cycle; writes drive RAM port a, reads drive
//   port b. Read data returns RD_LAT cycles after the grant, flagged to
//   the requester that issued it via a tag pipeline.
//
//   Build option: define SDP_RAM_ARB_RR_EN for round-robin arbitration.
//   Without it requester 0 has fixed priority and requester 1 may starve.
//
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     m{0,1}_req/we/be/addr/wdata  request fields, held until granted
//     m{0,1}_gnt                combinational grant
//     m{0,1}_rvalid             read data valid for that requester
//     rdata                     shared read data (ram_doutb passthrough)
//     ram_*                     connections to the SDP RAM
module sdp_ram_arb
   import sdp_ram_arb_pkg::*;
#(
   parameter int unsigned DATA_W          = 32,
   parameter int unsigned DEPTH_W         = 8,
   parameter int unsigned RD_LAT          = 2,
   parameter bit          USE_BYTE_ENABLE = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                m0_req,
   input  logic                m0_we,
   input  logic [DATA_W/8-1:0] m0_be,
   input  logic [DEPTH_W-1:0]  m0_addr,
   input  logic [DATA_W-1:0]   m0_wdata,
   output logic                m0_gnt,
   output logic                m0_rvalid,
   input  logic                m1_req,
   input  logic                m1_we,
   input  logic [DATA_W/8-1:0] m1_be,
   input  logic [DEPTH_W-1:0]  m1_addr,
   input  logic [DATA_W-1:0]   m1_wdata,
   output logic                m1_gnt,
   output logic                m1_rvalid,
   output logic [DATA_W-1:0]   rdata,
   output logic                ram_wea,
   output logic [DATA_W/8-1:0] ram_byte_enable,
   output logic                ram_reb,
   output logic [DEPTH_W-1:0]  ram_addra,
   output logic [DEPTH_W-1:0]  ram_addrb,
   output logic [DATA_W-1:0]   ram_dina,
   input  logic [DATA_W-1:0]   ram_doutb
);

   if (!legal_rd_lat(RD_LAT)) begin : g_bad_rd_lat
      $error("sdp_ram_arb: RD_LAT must be 1 or 2");
   end

   logic    gnt0, gnt1;
   logic    sel_we;
   rd_tag_t in_tag, out_tag;

`ifdef SDP_RAM_ARB_RR_EN
   logic last_id;

   // On contention the requester that did not win last time is granted.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst) begin
         if (m0_req && m1_req) begin
            if (last_id == ID_M0) gnt1 = 1'b1;
            else                  gnt0 = 1'b1;
         end else begin
            gnt0 = m0_req;
            gnt1 = m1_req;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)       last_id <= ID_M1;
      else if (gnt0) last_id <= ID_M0;
      else if (gnt1) last_id <= ID_M1;
   end
`else
   always_comb begin
      gnt0 = m0_req && !rst;
      gnt1 = m1_req && !m0_req && !rst;
   end
`endif

   // Requester 0 fields drive the RAM whenever requester 1 is not granted,
   // which keeps the idle outputs free of X.
   always_comb begin
      sel_we          = gnt1 ? m1_we : m0_we;
      ram_wea         = (gnt0 || gnt1) && sel_we;
      ram_reb         = (gnt0 || gnt1) && !sel_we;
      ram_addra       = gnt1 ? m1_addr  : m0_addr;
      ram_addrb       = gnt1 ? m1_addr  : m0_addr;
      ram_dina        = gnt1 ? m1_wdata : m0_wdata;
      ram_byte_enable = USE_BYTE_ENABLE ? (gnt1 ? m1_be : m0_be) : '1;
      in_tag.vld      = ram_reb;
      in_tag.id       = gnt1 ? ID_M1 : ID_M0;
   end

   sdp_ram_arb_tagpipe #(
      .DEPTH (RD_LAT)
   ) u_tagpipe (
      .clk     (clk),
      .rst     (rst),
      .in_tag  (in_tag),
      .out_tag (out_tag)
   );

   always_comb begin
      m0_gnt    = gnt0;
      m1_gnt    = gnt1;
      m0_rvalid = out_tag.vld && (out_tag.id == ID_M0) && !rst;
      m1_rvalid = out_tag.vld && (out_tag.id == ID_M1) && !rst;
      rdata     = ram_doutb;
   end

endmodule

// File: tb/tb_sdp_ram_arb.sv
module tb_sdp_ram_arb;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned DEPTH_W = 8;
   localparam int unsigned RD_LAT  = 2;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [3:0]  m0_be, m1_be;
   logic [7:0]  m0_addr, m1_addr;
   logic [31:0] m0_wdata, m1_wdata;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [31:0] rdata;
   logic        ram_wea, ram_reb;
   logic [3:0]  ram_byte_enable;
   logic [7:0]  ram_addra, ram_addrb;
   logic [31:0] ram_dina, ram_doutb;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sdp_ram_arb #(
      .DATA_W          (DATA_W),
      .DEPTH_W         (DEPTH_W),
      .RD_LAT          (RD_LAT),
      .USE_BYTE_ENABLE (1'b1)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .m0_req          (m0_req),
      .m0_we           (m0_we),
      .m0_be           (m0_be),
      .m0_addr         (m0_addr),
      .m0_wdata        (m0_wdata),
      .m0_gnt          (m0_gnt),
      .m0_rvalid       (m0_rvalid),
      .m1_req          (m1_req),
      .m1_we           (m1_we),
      .m1_be           (m1_be),
      .m1_addr         (m1_addr),
      .m1_wdata        (m1_wdata),
      .m1_gnt          (m1_gnt),
      .m1_rvalid       (m1_rvalid),
      .rdata           (rdata),
      .ram_wea         (ram_wea),
      .ram_byte_enable (ram_byte_enable),
      .ram_reb         (ram_reb),
      .ram_addra       (ram_addra),
      .ram_addrb       (ram_addrb),
      .ram_dina        (ram_dina),
      .ram_doutb       (ram_doutb)
   );

   // Behavioural SDP RAM with byte enables and RD_LAT read latency.
   logic [31:0] mem [256];
   logic [31:0] rq1, rq2;
   always @(posedge clk) begin
      if (ram_wea)
         for (int i = 0; i < 4; i++)
            if (ram_byte_enable[i]) mem[ram_addra][8*i +: 8] <= ram_dina[8*i +: 8];
      if (ram_reb) rq1 <= mem[ram_addrb];
      rq2 <= rq1;
   end
   assign ram_doutb = (RD_LAT == 2) ? rq2 : rq1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Monitor: every returned read is matched against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (m0_rvalid === 1'b1) begin
         checks++;
         if (q0.size() == 0) begin
            errors++;
            $display("FAIL m0_rvalid: unexpected at cycle %0d, rdata %h", cyc, rdata);
         end else begin
            e = q0.pop_front();
            if (rdata !== e.data || cyc != e.cyc) begin
               errors++;
               $display("FAIL m0_rdata: got %h at cycle %0d expected %h at cycle %0d", rdata, cyc, e.data, e.cyc);
            end
         end
      end
      if (m1_rvalid === 1'b1) begin
         checks++;
         if (q1.size() == 0) begin
            errors++;
            $display("FAIL m1_rvalid: unexpected at cycle %0d, rdata %h", cyc, rdata);
         end else begin
            e = q1.pop_front();
            if (rdata !== e.data || cyc != e.cyc) begin
               errors++;
               $display("FAIL m1_rdata: got %h at cycle %0d expected %h at cycle %0d", rdata, cyc, e.data, e.cyc);
            end
         end
      end
   end

   task automatic set_m0(input logic req, input logic we, input logic [3:0] be,
                         input logic [7:0] addr, input logic [31:0] wdata);
      m0_req = req; m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wdata;
   endtask

   task automatic set_m1(input logic req, input logic we, input logic [3:0] be,
                         input logic [7:0] addr, input logic [31:0] wdata);
      m1_req = req; m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wdata;
   endtask

   // One cycle: check grants and RAM port drive, queue the expected read.
   task automatic step(input logic eg0, input logic eg1, input logic [31:0] ed, input bit push);
      exp_t e;
      logic we;
      @(negedge clk);
      chk("m0_gnt", {31'b0, m0_gnt}, {31'b0, eg0});
      chk("m1_gnt", {31'b0, m1_gnt}, {31'b0, eg1});
      we = eg1 ? m1_we : m0_we;
      if (eg0 || eg1) begin
         if (we) begin
            chk("ram_wea", {31'b0, ram_wea}, 32'd1);
            chk("ram_reb", {31'b0, ram_reb}, 32'd0);
            chk("ram_addra", {24'b0, ram_addra}, {24'b0, eg1 ? m1_addr : m0_addr});
            chk("ram_dina", ram_dina, eg1 ? m1_wdata : m0_wdata);
            chk("ram_byte_enable", {28'b0, ram_byte_enable}, {28'b0, eg1 ? m1_be : m0_be});
         end else begin
            chk("ram_reb", {31'b0, ram_reb}, 32'd1);
            chk("ram_wea", {31'b0, ram_wea}, 32'd0);
            chk("ram_addrb", {24'b0, ram_addrb}, {24'b0, eg1 ? m1_addr : m0_addr});
            if (push) begin
               e.data = ed;
               e.cyc  = cyc + RD_LAT;
               if (eg1) q1.push_back(e);
               else     q0.push_back(e);
            end
         end
      end else begin
         chk("ram_wea_idle", {31'b0, ram_wea}, 32'd0);
         chk("ram_reb_idle", {31'b0, ram_reb}, 32'd0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      set_m0(0, 0, 4'h0, 8'h00, 32'h0);
      set_m1(0, 0, 4'h0, 8'h00, 32'h0);
      for (int i = 0; i < n; i++) step(0, 0, 32'h0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic rr;
      logic w;
`ifdef SDP_RAM_ARB_RR_EN
      rr = 1'b1;
`else
      rr = 1'b0;
`endif
      rst = 1'b1;
      set_m0(1, 0, 4'hF, 8'd5, 32'h0);
      set_m1(1, 0, 4'hF, 8'd2, 32'h0);
      @(posedge clk); #1;
      // Requests during reset must not be granted.
      for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 0);
      rst = 1'b0;

      // Preload through the write port.
      set_m0(0, 0, 4'h0, 8'h00, 32'h0);
      set_m1(1, 1, 4'hF, 8'd5, 32'hDEADBEEF); step(0, 1, 32'h0, 0);
      set_m1(1, 1, 4'hF, 8'd1, 32'h00000011); step(0, 1, 32'h0, 0);
      set_m1(1, 1, 4'hF, 8'd2, 32'h00000022); step(0, 1, 32'h0, 0);
      set_m1(1, 1, 4'hF, 8'd3, 32'h00000000); step(0, 1, 32'h0, 0);
      idle(1);

      // Reset again so contention starts from the reset priority state.
      rst = 1'b1; step(0, 0, 32'h0, 0); rst = 1'b0;

      // Contention: both read every cycle.
      set_m0(1, 0, 4'hF, 8'd1, 32'h0);
      set_m1(1, 0, 4'hF, 8'd2, 32'h0);
      for (int k = 0; k < 4; k++) begin
         w = rr & k[0];
         step(!w, w, w ? 32'h00000022 : 32'h00000011, 1);
      end
      idle(3);

      // Single read of preloaded word.
      set_m0(1, 0, 4'hF, 8'd5, 32'h0); step(1, 0, 32'hDEADBEEF, 1);
      idle(3);

      // Write from m1 then read-after-write from m0 on the next cycle.
      set_m1(1, 1, 4'hF, 8'd7, 32'hA5A5A5A5); step(0, 1, 32'h0, 0);
      set_m1(0, 0, 4'h0, 8'd0, 32'h0);
      set_m0(1, 0, 4'hF, 8'd7, 32'h0);        step(1, 0, 32'hA5A5A5A5, 1);
      idle(2);

      // Partial byte write into a zero word.
      set_m0(1, 1, 4'b0010, 8'd3, 32'h12345678); step(1, 0, 32'h0, 0);
      set_m0(1, 0, 4'hF, 8'd3, 32'h0);           step(1, 0, 32'h00005600, 1);
      idle(2);

      // Back-to-back reads from m1 with m0 idle.
      set_m0(0, 0, 4'h0, 8'd0, 32'h0);
      set_m1(1, 0, 4'hF, 8'd1, 32'h0); step(0, 1, 32'h00000011, 1);
      set_m1(1, 0, 4'hF, 8'd2, 32'h0); step(0, 1, 32'h00000022, 1);
      set_m1(1, 0, 4'hF, 8'd1, 32'h0); step(0, 1, 32'h00000011, 1);
      idle(3);

      // Address extremes.
      set_m0(1, 1, 4'hF, 8'd0,   32'h0BADF00D); step(1, 0, 32'h0, 0);
      set_m0(1, 1, 4'hF, 8'd255, 32'hCAFEF00D); step(1, 0, 32'h0, 0);
      set_m0(1, 0, 4'hF, 8'd255, 32'h0);        step(1, 0, 32'hCAFEF00D, 1);
      set_m0(1, 0, 4'hF, 8'd0,   32'h0);        step(1, 0, 32'h0BADF00D, 1);
      idle(3);

      // Reset while a read is in flight: its response must be dropped.
      set_m0(1, 0, 4'hF, 8'd5, 32'h0); step(1, 0, 32'h0, 0);
      set_m0(0, 0, 4'h0, 8'd0, 32'h0);
      rst = 1'b1; step(0, 0, 32'h0, 0); rst = 1'b0;
      idle(4);

      // First conflict after reset goes to m0.
      set_m0(1, 0, 4'hF, 8'd1, 32'h0);
      set_m1(1, 0, 4'hF, 8'd2, 32'h0);
      step(1, 0, 32'h00000011, 1);
      step(!rr, rr, rr ? 32'h00000022 : 32'h00000011, 1);
      idle(RD_LAT + 2);

      chk("q0_drained", q0.size(), 32'd0);
      chk("q1_drained", q1.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
